// File: rtl/equiv_stream_checker.sv
// Skew-tolerant equivalence checker: buffers two valid-qualified result streams,
// compares heads in order, keeps saturating statistics and captures the first mismatch.
module esc_fifo #(
  parameter int W     = 91,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         empty_nxt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty.
  assign empty_o     = (wr_q == rd_q);
  assign full_o      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign wr_d        = wr_q + (AW+1)'(push_i);
  assign rd_d        = rd_q + (AW+1)'(pop_i);
  assign empty_nxt_o = (wr_d == rd_d);
  assign data_o      = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

module equiv_stream_checker #(
  parameter int W            = 91,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             a_valid,
  input  logic [W-1:0]     a_data,
  input  logic             b_valid,
  input  logic [W-1:0]     b_data,
  output logic             fail,
  output logic             ovf,
  output logic             busy,
  output logic [CNT_W-1:0] cmp_count,
  output logic [CNT_W-1:0] mis_count,
  output logic [CNT_W-1:0] first_idx,
  output logic [W-1:0]     first_diff,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {RUN = 2'd0, FAILED = 2'd1, HALTED = 2'd2} state_e;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             fail_q, fail_d, ovf_q, ovf_d, busy_q, busy_d;
  logic [CNT_W-1:0] cmp_q, cmp_d, mis_q, mis_d, idx_q, idx_d;
  logic [W-1:0]     diff_q, diff_d;

  logic         a_empty, a_full, a_empty_nxt, a_push, a_ovf;
  logic         b_empty, b_full, b_empty_nxt, b_push, b_ovf;
  logic [W-1:0] a_head, b_head;
  logic         live, cmp_ok, cmp, mism;

  assign live   = (state_q != HALTED);
  assign cmp_ok = (state_q == RUN) || (state_q == FAILED && STOP_ON_FAIL == 0);
  assign cmp    = cmp_ok && !a_empty && !b_empty;
  assign mism   = cmp && (a_head != b_head);
  // A full FIFO may still accept a push in the cycle its head is popped.
  assign a_push = live && a_valid && (!a_full || cmp);
  assign b_push = live && b_valid && (!b_full || cmp);
  assign a_ovf  = live && a_valid && a_full && !cmp;
  assign b_ovf  = live && b_valid && b_full && !cmp;

  esc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push_i(a_push), .pop_i(cmp),
    .data_i(a_data), .data_o(a_head), .empty_o(a_empty), .full_o(a_full),
    .empty_nxt_o(a_empty_nxt)
  );

  esc_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push_i(b_push), .pop_i(cmp),
    .data_i(b_data), .data_o(b_head), .empty_o(b_empty), .full_o(b_full),
    .empty_nxt_o(b_empty_nxt)
  );

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    ovf_d   = ovf_q;
    cmp_d   = cmp_q;
    mis_d   = mis_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    busy_d  = !(a_empty_nxt && b_empty_nxt);
    if (cmp && cmp_q != CNT_MAX) cmp_d = cmp_q + 1'b1;
    if (mism) begin
      if (mis_q != CNT_MAX) mis_d = mis_q + 1'b1;
      if (!fail_q) begin
        fail_d = 1'b1;
        idx_d  = cmp_q;
        diff_d = a_head ^ b_head;
      end
      if (state_q == RUN) state_d = FAILED;
    end
    // Overflow wins over a same-cycle mismatch.
    if (a_ovf || b_ovf) begin
      ovf_d   = 1'b1;
      state_d = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= RUN;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      cmp_q   <= '0;
      mis_q   <= '0;
      idx_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      cmp_q   <= cmp_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
    end
  end

  assign fail       = fail_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;
  assign cmp_count  = cmp_q;
  assign mis_count  = mis_q;
  assign first_idx  = idx_q;
  assign first_diff = diff_q;
  assign state      = state_q;
endmodule
